// File: rtl/if_id_fifo_pkg.sv
// Shared constants for the IF/ID instruction buffer.
package if_id_fifo_pkg;

  localparam int unsigned IfIdDepth   = 4;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        FlushEnable = 1'b1;
  localparam logic        Stop        = 1'b1;
  localparam logic        NoStop      = 1'b0;

endpackage

// File: rtl/if_id_fifo.sv
// In-order {pc, inst} buffer between fetch and decode with valid/ready on both sides,
// synchronous flush for redirects, and a decode-side stall that blocks pops only.
module if_id_fifo
  import if_id_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = IfIdDepth,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              if_ready,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [PTR_W:0]    count_o
);

  localparam int unsigned    EntW      = ADDR_W + INST_W;
  localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

  logic [EntW-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop, flush;
  logic [EntW-1:0]  head;

  always_comb begin
    // if_ready depends only on occupancy, keeping id_ready off the fetch-side path.
    if_ready = (count_q != FullCount);
    id_valid = (count_q != '0);
    flush    = (flush_i == FlushEnable);
    push     = if_valid & if_ready;
    pop      = id_valid & id_ready & (stall_i == NoStop);
    count_o  = count_q;

    head    = mem_q[rd_ptr_q];
    id_pc   = id_valid ? head[EntW-1:INST_W] : ADDR_W'(ZeroWord);
    id_inst = id_valid ? head[INST_W-1:0]    : INST_W'(ZeroWord);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; occupancy gating hides stale contents.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= {if_pc, if_inst};
    end
  end

  assert property (@(posedge clk) disable iff (!rst) count_q <= FullCount);

endmodule

// File: tb/tb_if_id_fifo.sv
// Directed and randomized checks of if_id_fifo against a queue-based reference model.
module tb_if_id_fifo;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_inst = '0;
  logic        if_ready;
  logic        flush_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  count_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: list of {pc, inst} in arrival order.
  logic [63:0] q[$];

  if_id_fifo #(
    .ADDR_W(32),
    .INST_W(32),
    .DEPTH (Depth)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .if_valid(if_valid),
    .if_pc   (if_pc),
    .if_inst (if_inst),
    .if_ready(if_ready),
    .flush_i (flush_i),
    .stall_i (stall_i),
    .id_ready(id_ready),
    .id_valid(id_valid),
    .id_pc   (id_pc),
    .id_inst (id_inst),
    .count_o (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [63:0] head;
    head = (q.size() != 0) ? q[0] : 64'h0;
    chk({tag, ".id_valid"}, 64'(id_valid), 64'(q.size() != 0));
    chk({tag, ".id_pc"},    64'(id_pc),    64'(head[63:32]));
    chk({tag, ".id_inst"},  64'(id_inst),  64'(head[31:0]));
    chk({tag, ".count"},    64'(count_o),  64'(q.size()));
    chk({tag, ".if_ready"}, 64'(if_ready), 64'(q.size() != Depth));
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
  task automatic cycle(input string tag, input logic v, input logic [31:0] pc,
                       input logic [31:0] inst, input logic rdy, input logic st,
                       input logic fl);
    bit push, pop;
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    id_ready = rdy;
    stall_i  = st;
    flush_i  = fl;
    push = v && (q.size() != Depth);
    pop  = (q.size() != 0) && rdy && !st;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back({pc, inst});
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    if_valid = 1'b0;
    id_ready = 1'b0;
    stall_i  = 1'b0;
    flush_i  = 1'b0;
  endtask

  initial begin
    // Power-on reset.
    #2;
    check_all("por");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_rst");

    // 1: asynchronous reset mid-operation.
    for (int i = 0; i < 3; i++) cycle("t1.load", 1'b1, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i),
                                      1'b0, 1'b0, 1'b0);
    idle_inputs();
    #2;
    rst = 1'b0;
    q.delete();
    #1;
    check_all("t1.async");
    @(negedge clk);
    rst = 1'b1;

    // 2: single push becomes visible after one edge.
    cycle("t2", 1'b1, 32'h1000, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    chk("t2.pc", 64'(id_pc), 64'h1000);
    chk("t2.cnt", 64'(count_o), 64'd1);
    cycle("t2.pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // 3: fill past full, then drain in order.
    for (int i = 0; i < 5; i++) cycle("t3.fill", 1'b1, 32'(4 * i), 32'hB000 + 32'(i),
                                      1'b0, 1'b0, 1'b0);
    chk("t3.full_rdy", 64'(if_ready), 64'd0);
    chk("t3.full_cnt", 64'(count_o), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t3.drain_pc", 64'(id_pc), 64'(4 * i));
      cycle("t3.drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    end

    // 4: simultaneous push and pop at count 2.
    cycle("t4.a", 1'b1, 32'h18, 32'h1, 1'b0, 1'b0, 1'b0);
    cycle("t4.b", 1'b1, 32'h1C, 32'h2, 1'b0, 1'b0, 1'b0);
    cycle("t4.pp", 1'b1, 32'h20, 32'h3, 1'b1, 1'b0, 1'b0);
    chk("t4.cnt", 64'(count_o), 64'd2);
    chk("t4.head", 64'(id_pc), 64'h1C);
    for (int i = 0; i < 2; i++) cycle("t4.drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("t4.empty", 64'(id_valid), 64'd0);

    // 5: stream 12 entries across wraps with a stall on cycles 3-5.
    for (int i = 0; i < 12; i++) cycle("t5.stream", 1'b1, 32'h200 + 32'(4 * i), 32'(i),
                                       1'b1, (i >= 3 && i <= 5), 1'b0);
    for (int i = 0; i < 6; i++) cycle("t5.drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("t5.empty", 64'(count_o), 64'd0);

    // 6: flush beats a concurrent push.
    for (int i = 0; i < 3; i++) cycle("t6.load", 1'b1, 32'h30 + 32'(4 * i), 32'(i),
                                      1'b0, 1'b0, 1'b0);
    cycle("t6.flush", 1'b1, 32'h40, 32'h40, 1'b1, 1'b0, 1'b1);
    chk("t6.cnt", 64'(count_o), 64'd0);
    chk("t6.valid", 64'(id_valid), 64'd0);
    cycle("t6.push", 1'b1, 32'h44, 32'h44, 1'b0, 1'b0, 1'b0);
    chk("t6.head", 64'(id_pc), 64'h44);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle("rnd", 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 30) == 0));
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
